// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage and the fixed-field
// stage wrappers that pack their fields into its payload/control buses.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int DEF_DATA_BITS      = 64;
  localparam int DEF_CTRL_BITS      = 16;
  localparam int DEF_STALL_CNT_BITS = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; also intended
// for the hazard unit's performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Flow-controlled pipeline stage register with a 2-entry skid buffer,
// synchronous flush with control zeroing, and a saturating stall counter.
//
//  state | meaning
//  EMPTY | nothing held, m_valid low, m_ctrl forced to 0
//  ONE   | main register holds the presented entry
//  TWO   | main presented, skid holds the next entry, s_ready low
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int CTRL_BITS      = DEF_CTRL_BITS,
  parameter bit CLEAR_DATA     = 1'b1,
  parameter int STALL_CNT_BITS = DEF_STALL_CNT_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_BITS-1:0]      s_data,
  input  logic [CTRL_BITS-1:0]      s_ctrl,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_BITS-1:0]      m_data,
  output logic [CTRL_BITS-1:0]      m_ctrl,
  output logic [1:0]                occupancy,
  output logic [STALL_CNT_BITS-1:0] stall_cycles
);

  pipe_state_t          r_state;
  pipe_state_t          w_next;
  logic                 r_s_ready;
  logic [DATA_BITS-1:0] r_main_data;
  logic [CTRL_BITS-1:0] r_main_ctrl;
  logic [DATA_BITS-1:0] r_skid_data;
  logic [CTRL_BITS-1:0] r_skid_ctrl;
  logic                 w_s_fire;
  logic                 w_ld_main_in;
  logic                 w_ld_main_skid;
  logic                 w_ld_skid;
  logic                 w_stall;

  assign w_s_fire = s_valid & r_s_ready;

  always_comb begin
    w_next         = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_s_fire) begin
            w_next       = ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (w_s_fire && m_ready) begin
            w_ld_main_in = 1'b1;
          end else if (w_s_fire) begin
            w_next    = TWO;
            w_ld_skid = 1'b1;
          end else if (m_ready) begin
            w_next = EMPTY;
          end
        end
        TWO: begin
          if (m_ready) begin
            w_next         = ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_s_ready   <= 1'b1;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state   <= w_next;
      // s_ready depends only on registered state, never on m_ready this cycle
      r_s_ready <= (w_next != TWO);
      if (flush) begin
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
        if (CLEAR_DATA) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end
      end else begin
        if (w_ld_main_in) begin
          r_main_data <= s_data;
          r_main_ctrl <= s_ctrl;
        end else if (w_ld_main_skid) begin
          r_main_data <= r_skid_data;
          r_main_ctrl <= r_skid_ctrl;
        end else if (w_next == EMPTY) begin
          r_main_ctrl <= '0;
        end
        if (w_ld_skid) begin
          r_skid_data <= s_data;
          r_skid_ctrl <= s_ctrl;
        end
      end
    end
  end

  assign w_stall = (r_state != EMPTY) & ~m_ready;

  sat_counter #(
    .WIDTH(STALL_CNT_BITS)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_stall),
    .i_clr  (1'b0),
    .o_count(stall_cycles)
  );

  assign s_ready   = r_s_ready;
  assign m_valid   = (r_state != EMPTY);
  assign m_data    = r_main_data;
  assign m_ctrl    = r_main_ctrl;
  assign occupancy = r_state;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed scenarios plus randomized traffic
// against a queue-based reference model; three parameterisations share stimulus.
module tb_elastic_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, s_valid, m_ready;
  logic [63:0] s_data;
  logic [15:0] s_ctrl;

  logic        a_s_ready, a_m_valid, b_s_ready, b_m_valid, c_s_ready, c_m_valid;
  logic [63:0] a_m_data, b_m_data, c_m_data;
  logic [15:0] a_m_ctrl, b_m_ctrl, c_m_ctrl;
  logic [1:0]  a_occ, b_occ, c_occ;
  logic [15:0] a_stall, b_stall;
  logic [3:0]  c_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  elastic_pipe_reg dut_a (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(a_s_ready),
    .s_data(s_data), .s_ctrl(s_ctrl), .m_valid(a_m_valid), .m_ready(m_ready),
    .m_data(a_m_data), .m_ctrl(a_m_ctrl), .occupancy(a_occ), .stall_cycles(a_stall));

  elastic_pipe_reg #(.CLEAR_DATA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(b_s_ready),
    .s_data(s_data), .s_ctrl(s_ctrl), .m_valid(b_m_valid), .m_ready(m_ready),
    .m_data(b_m_data), .m_ctrl(b_m_ctrl), .occupancy(b_occ), .stall_cycles(b_stall));

  elastic_pipe_reg #(.STALL_CNT_BITS(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .s_valid(s_valid), .s_ready(c_s_ready),
    .s_data(s_data), .s_ctrl(s_ctrl), .m_valid(c_m_valid), .m_ready(m_ready),
    .m_data(c_m_data), .m_ctrl(c_m_ctrl), .occupancy(c_occ), .stall_cycles(c_stall));

  // Reference model: FIFO of held entries plus what m_data shows when empty.
  typedef struct { logic [63:0] d; logic [15:0] c; } ent_t;
  ent_t        q[$];
  bit          mdl_rdy;
  bit          mdl_sfire;
  int unsigned mdl_cnt, mdl_sat;
  logic [63:0] last_clr, last_nc;

  task automatic model_update();
    ent_t e;
    bit   mfire;
    if (rst) begin
      q.delete();
      mdl_rdy = 1; mdl_sfire = 0; mdl_cnt = 0; mdl_sat = 0;
      last_clr = '0; last_nc = '0;
    end else begin
      if (q.size() > 0 && !m_ready) begin
        if (mdl_cnt < 65535) mdl_cnt++;
        if (mdl_sat < 15) mdl_sat++;
      end
      mdl_sfire = s_valid && mdl_rdy;
      mfire = (q.size() > 0) && m_ready;
      if (q.size() > 0) begin last_clr = q[0].d; last_nc = q[0].d; end
      if (flush) begin
        q.delete();
        last_clr = '0;
        mdl_rdy = 1;
      end else begin
        if (mfire) void'(q.pop_front());
        if (mdl_sfire) begin e.d = s_data; e.c = s_ctrl; q.push_back(e); end
        mdl_rdy = (q.size() < 2);
      end
    end
  endtask

  function automatic logic [63:0] exp_data(bit clr);
    if (q.size() > 0) return q[0].d;
    return clr ? last_clr : last_nc;
  endfunction

  function automatic logic [15:0] exp_ctrl();
    if (q.size() > 0) return q[0].c;
    return 16'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; s_valid = 0; m_ready = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; s_valid = 1; m_ready = 0;
    s_data = 64'hFFFF_0000_1234_5678; s_ctrl = 16'hFFFF;
    step(); step();
    rst = 0; s_valid = 0;
    n_checks++; if (a_m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid: got %b exp 0", a_m_valid); end
    n_checks++; if (a_m_data !== 64'h0) begin n_errors++; $display("FAIL reset_m_data: got %h exp 0", a_m_data); end
    n_checks++; if (a_m_ctrl !== 16'h0) begin n_errors++; $display("FAIL reset_m_ctrl: got %h exp 0", a_m_ctrl); end
    n_checks++; if (a_occ !== 2'd0) begin n_errors++; $display("FAIL reset_occupancy: got %0d exp 0", a_occ); end
    n_checks++; if (a_s_ready !== 1'b1) begin n_errors++; $display("FAIL reset_s_ready: got %b exp 1", a_s_ready); end
    n_checks++; if (a_stall !== 16'd0) begin n_errors++; $display("FAIL reset_stall: got %0d exp 0", a_stall); end
    n_checks++; if (b_m_data !== 64'h0) begin n_errors++; $display("FAIL reset_nc_m_data: got %h exp 0", b_m_data); end
  endtask

  task automatic test_stream();
    m_ready = 1; s_ctrl = 16'hA5A5;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1; s_data = 64'(i);
      step();
      n_checks++; if (a_m_valid !== 1'b1 || a_m_data !== 64'(i)) begin n_errors++; $display("FAIL stream_data: got v=%b d=%0d exp v=1 d=%0d", a_m_valid, a_m_data, i); end
      n_checks++; if (a_m_ctrl !== 16'hA5A5) begin n_errors++; $display("FAIL stream_ctrl: got %h exp a5a5", a_m_ctrl); end
      n_checks++; if (a_s_ready !== 1'b1 || a_occ > 2'd1) begin n_errors++; $display("FAIL stream_ready_occ: got rdy=%b occ=%0d exp rdy=1 occ<=1", a_s_ready, a_occ); end
    end
    s_valid = 0;
    step();
    n_checks++; if (a_m_valid !== 1'b0 || a_m_ctrl !== 16'h0) begin n_errors++; $display("FAIL stream_bubble: got v=%b ctrl=%h exp v=0 ctrl=0", a_m_valid, a_m_ctrl); end
  endtask

  task automatic test_single_stall();
    logic [63:0] src[$];
    logic [63:0] outs[$];
    int maxocc = 0, nrdy = 0;
    bit dropped = 0;
    do_reset();
    src = '{64'd1, 64'd2, 64'd3, 64'd4};
    s_ctrl = 16'h00C3;
    for (int cyc = 0; cyc < 12; cyc++) begin
      m_ready = 1;
      if (!dropped && q.size() > 0 && q[0].d == 64'd2) begin m_ready = 0; dropped = 1; end
      s_valid = (src.size() > 0);
      s_data  = (src.size() > 0) ? src[0] : 64'h0;
      if (a_m_valid && m_ready) outs.push_back(a_m_data);
      step();
      if (mdl_sfire) void'(src.pop_front());
      if (int'(a_occ) > maxocc) maxocc = int'(a_occ);
      if (!a_s_ready) nrdy++;
    end
    s_valid = 0;
    n_checks++; if (outs.size() != 4) begin n_errors++; $display("FAIL stall1_count: got %0d exp 4", outs.size()); end
    for (int k = 0; k < outs.size() && k < 4; k++) begin
      n_checks++; if (outs[k] !== 64'(k + 1)) begin n_errors++; $display("FAIL stall1_order[%0d]: got %0d exp %0d", k, outs[k], k + 1); end
    end
    n_checks++; if (maxocc != 2) begin n_errors++; $display("FAIL stall1_maxocc: got %0d exp 2", maxocc); end
    n_checks++; if (nrdy != 1) begin n_errors++; $display("FAIL stall1_sready_low: got %0d exp 1", nrdy); end
    n_checks++; if (a_stall !== 16'd1) begin n_errors++; $display("FAIL stall1_cycles: got %0d exp 1", a_stall); end
  endtask

  task automatic test_long_stall();
    logic [63:0] outs[$];
    int acc = 0, nrdy = 0;
    do_reset();
    m_ready = 1; s_valid = 1; s_data = 64'd100; s_ctrl = 16'h0011;
    if (a_s_ready) acc++;
    step();
    m_ready = 0;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1; s_data = 64'(101 + k);
      if (a_s_ready) acc++; else nrdy++;
      step();
    end
    n_checks++; if (acc != 2) begin n_errors++; $display("FAIL long_accepted: got %0d exp 2", acc); end
    n_checks++; if (nrdy != 9) begin n_errors++; $display("FAIL long_sready_low: got %0d exp 9", nrdy); end
    n_checks++; if (a_occ !== 2'd2) begin n_errors++; $display("FAIL long_occ: got %0d exp 2", a_occ); end
    n_checks++; if (a_stall !== 16'd10) begin n_errors++; $display("FAIL long_stall_cycles: got %0d exp 10", a_stall); end
    m_ready = 1; s_valid = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_m_valid) outs.push_back(a_m_data);
      step();
    end
    n_checks++; if (outs.size() != 2) begin n_errors++; $display("FAIL long_drain_count: got %0d exp 2", outs.size()); end
    else begin
      n_checks++; if (outs[0] !== 64'd100 || outs[1] !== 64'd101) begin n_errors++; $display("FAIL long_drain_order: got %0d,%0d exp 100,101", outs[0], outs[1]); end
    end
  endtask

  task automatic test_flush_two();
    int seen = 0;
    do_reset();
    m_ready = 1; s_valid = 1; s_data = 64'h11; s_ctrl = 16'h1234;
    step();
    m_ready = 0; s_data = 64'h22; s_ctrl = 16'h5678;
    step();
    n_checks++; if (a_occ !== 2'd2) begin n_errors++; $display("FAIL flush_pre_occ: got %0d exp 2", a_occ); end
    flush = 1; s_valid = 1; s_data = 64'hDEAD; s_ctrl = 16'hFFFF;
    step();
    flush = 0; s_valid = 0;
    n_checks++; if (a_m_valid !== 1'b0 || a_m_ctrl !== 16'h0) begin n_errors++; $display("FAIL flush_valid_ctrl: got v=%b ctrl=%h exp v=0 ctrl=0", a_m_valid, a_m_ctrl); end
    n_checks++; if (a_m_data !== 64'h0) begin n_errors++; $display("FAIL flush_data_clear: got %h exp 0", a_m_data); end
    n_checks++; if (a_occ !== 2'd0 || a_s_ready !== 1'b1) begin n_errors++; $display("FAIL flush_occ_ready: got occ=%0d rdy=%b exp occ=0 rdy=1", a_occ, a_s_ready); end
    n_checks++; if (a_stall !== 16'd2) begin n_errors++; $display("FAIL flush_stall_kept: got %0d exp 2", a_stall); end
    n_checks++; if (b_m_data !== 64'h11 || b_m_ctrl !== 16'h0 || b_m_valid !== 1'b0) begin n_errors++; $display("FAIL flush_nc_hold: got d=%h c=%h v=%b exp d=11 c=0 v=0", b_m_data, b_m_ctrl, b_m_valid); end
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin step(); if (a_m_valid) seen++; end
    n_checks++; if (seen != 0) begin n_errors++; $display("FAIL flush_no_present: got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 0; s_valid = 1; s_data = 64'h55; s_ctrl = 16'h00AA;
    step();
    s_valid = 0;
    n_checks++; if (a_occ !== 2'd1) begin n_errors++; $display("FAIL rstmid_pre_occ: got %0d exp 1", a_occ); end
    rst = 1; s_valid = 1; s_data = 64'h66;
    step();
    rst = 0; s_valid = 0;
    n_checks++; if (a_m_valid !== 1'b0 || a_m_data !== 64'h0 || a_m_ctrl !== 16'h0) begin n_errors++; $display("FAIL rstmid_outputs: got v=%b d=%h c=%h exp all 0", a_m_valid, a_m_data, a_m_ctrl); end
    n_checks++; if (a_occ !== 2'd0 || a_s_ready !== 1'b1 || a_stall !== 16'd0) begin n_errors++; $display("FAIL rstmid_state: got occ=%0d rdy=%b stall=%0d exp 0,1,0", a_occ, a_s_ready, a_stall); end
    n_checks++; if (b_m_data !== 64'h0 || b_m_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_nc: got d=%h v=%b exp 0,0", b_m_data, b_m_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1; s_valid = 1; s_data = 64'h77; s_ctrl = 16'h0001;
    step();
    m_ready = 0; s_valid = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++; if (c_stall !== 4'((k < 15) ? k : 15)) begin n_errors++; $display("FAIL sat_count[%0d]: got %0d exp %0d", k, c_stall, (k < 15) ? k : 15); end
    end
    n_checks++; if (a_stall !== 16'd20) begin n_errors++; $display("FAIL sat_wide_count: got %0d exp 20", a_stall); end
    m_ready = 1;
    step(); step();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst     = ($urandom_range(0, 199) == 0);
      flush   = ($urandom_range(0, 24) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 9) < 7);
      s_data  = {$urandom, $urandom};
      s_ctrl  = 16'($urandom);
      step();
      n_checks++;
      if (a_m_valid !== (q.size() > 0) || a_occ !== 2'(q.size()) || a_s_ready !== mdl_rdy ||
          a_m_data !== exp_data(1'b1) || a_m_ctrl !== exp_ctrl() || a_stall !== 16'(mdl_cnt)) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_a[%0d]: got v=%b occ=%0d rdy=%b d=%h c=%h st=%0d exp v=%b occ=%0d rdy=%b d=%h c=%h st=%0d",
          cyc, a_m_valid, a_occ, a_s_ready, a_m_data, a_m_ctrl, a_stall,
          q.size() > 0, q.size(), mdl_rdy, exp_data(1'b1), exp_ctrl(), mdl_cnt);
      end
      n_checks++;
      if (b_m_data !== exp_data(1'b0) || b_m_ctrl !== exp_ctrl() || b_m_valid !== (q.size() > 0)) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_nc[%0d]: got d=%h c=%h v=%b exp d=%h c=%h", cyc, b_m_data, b_m_ctrl, b_m_valid, exp_data(1'b0), exp_ctrl());
      end
      n_checks++;
      if (c_stall !== 4'(mdl_sat) || c_m_data !== exp_data(1'b1)) begin
        n_errors++; bad++;
        if (bad < 10) $display("FAIL rand_sat[%0d]: got st=%0d d=%h exp st=%0d d=%h", cyc, c_stall, c_m_data, mdl_sat, exp_data(1'b1));
      end
    end
    rst = 0; flush = 0; s_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; s_valid = 0; m_ready = 0; s_data = '0; s_ctrl = '0;
    mdl_rdy = 1; mdl_sfire = 0; mdl_cnt = 0; mdl_sat = 0; last_clr = '0; last_nc = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_single_stall();
    test_long_stall();
    test_flush_two();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
